cool_heat_controller: RTL

- Closed-loop controller that sits directly upstream of the fan/heater PWM stage and drives that stage's 8-bit `speed` duty input.
- Compares sampled temperature against a setpoint, with hysteresis, to select cooling or heating.
- Derives a proportional target duty and slew-limits `speed` toward it.
- Mode changes always drain `speed` to 0 first, so the actuator never switches mode while powered.

---
 rtl/cool_heat_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cool_heat_controller.sv
`default_nettype none
// ============================================================================
// Module      : cool_heat_controller
// Description : Hysteretic cool/heat mode selection with a proportional,
//               slew-limited 8-bit duty command for the downstream PWM stage.
//               Any mode change drains the duty to 0 before switching.
//               Optional over-temperature alarm: COOL_HEAT_CONTROLLER_ALARM_EN
// Revision    : 1.0 - initial release
// ============================================================================
module cool_heat_controller #(
  parameter int HYST       = 2,
  parameter int GAIN       = 16,
  parameter int STEP       = 8,
  parameter int RAMP_DIV   = 16,
  parameter int ALARM_TEMP = 200
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] temp_in,
  input  logic       temp_valid,
  input  logic [7:0] setpoint,
  output logic [7:0] speed,
  output logic       cool_on,
  output logic       heat_on,
  output logic       alarm
);

  localparam int            CW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] TICK_AT = CW'(RAMP_DIV - 1);
  localparam logic [8:0]    HYST9   = 9'(HYST);
  localparam logic [8:0]    STEP9   = 9'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOL  = 2'd1,
    HEAT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    temp_q;
  logic          seen;
  logic          drain_mode;     // 0 = draining from cool, 1 = from heat
  logic          drain_mode_nx;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [8:0]    temp9;
  logic [8:0]    sp9;
  logic [8:0]    hi;
  logic [8:0]    lo;
  logic [7:0]    cool_tgt;
  logic [7:0]    heat_tgt;
  logic [7:0]    target;
  logic          jump;           // alarm path: bypass the slew limit
  logic [8:0]    up_sum;
  logic [8:0]    dn_lim;
  logic [7:0]    speed_nx;
  logic          alarm_i;

  // Error times gain, computed wide and saturated to the 8-bit duty range
  function automatic logic [7:0] scale(input logic [8:0] diff);
    logic [31:0] prod;
    prod = 32'(diff) * 32'(GAIN);
    return (prod > 32'd255) ? 8'hFF : prod[7:0];
  endfunction

  assign temp9    = {1'b0, temp_q};
  assign sp9      = {1'b0, setpoint};
  assign hi       = sp9 + HYST9;
  assign lo       = (sp9 >= HYST9) ? (sp9 - HYST9) : 9'd0;
  assign cool_tgt = scale((temp9 > sp9) ? (temp9 - sp9) : 9'd0);
  assign heat_tgt = scale((sp9 > temp9) ? (sp9 - temp9) : 9'd0);
  assign tick     = (tick_cnt == TICK_AT);

`ifdef COOL_HEAT_CONTROLLER_ALARM_EN
  assign alarm_i = seen && (temp9 >= 9'(ALARM_TEMP));
`else
  assign alarm_i = 1'b0;
`endif
  assign alarm = alarm_i;

  // Next state, drain direction and the target duty of the current state
  always_comb begin
    state_nx      = state;
    drain_mode_nx = drain_mode;
    target        = 8'd0;
    jump          = 1'b0;
    if (alarm_i) begin
      // Force cooling; heating must still drain to 0 before the switch
      case (state)
        IDLE:    state_nx = COOL;
        COOL:    begin target = 8'hFF; jump = 1'b1; end
        HEAT:    begin target = heat_tgt; state_nx = DRAIN; drain_mode_nx = 1'b1; end
        DRAIN:   if (!drain_mode || speed == 8'd0) state_nx = COOL;
        default: state_nx = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (temp9 > hi)      state_nx = COOL;
          else if (temp9 < lo) state_nx = HEAT;
        end
        COOL: begin
          target = cool_tgt;
          if (temp9 <= sp9) begin state_nx = DRAIN; drain_mode_nx = 1'b0; end
        end
        HEAT: begin
          target = heat_tgt;
          if (temp9 >= sp9) begin state_nx = DRAIN; drain_mode_nx = 1'b1; end
        end
        DRAIN:   if (speed == 8'd0) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
    // No decisions are taken until a real sample has arrived
    if (!seen) begin
      state_nx      = state;
      drain_mode_nx = drain_mode;
    end
  end

  // Slew-limited step toward target without overshoot or 8-bit wrap
  always_comb begin
    up_sum   = {1'b0, speed} + STEP9;
    dn_lim   = {1'b0, target} + STEP9;
    speed_nx = speed;
    if (jump)
      speed_nx = target;
    else if (speed < target)
      speed_nx = (up_sum > {1'b0, target}) ? target : up_sum[7:0];
    else if (speed > target)
      speed_nx = ({1'b0, speed} > dn_lim) ? (speed - 8'(STEP)) : target;
  end

  // Mode FSM with registered actuator selects
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state      <= IDLE;
      drain_mode <= 1'b0;
      cool_on    <= 1'b0;
      heat_on    <= 1'b0;
    end else begin
      state      <= state_nx;
      drain_mode <= drain_mode_nx;
      cool_on    <= (state_nx == COOL) || (state_nx == DRAIN && !drain_mode_nx);
      heat_on    <= (state_nx == HEAT) || (state_nx == DRAIN &&  drain_mode_nx);
    end
  end

  // Temperature sample register
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      temp_q <= 8'd0;
      seen   <= 1'b0;
    end else if (temp_valid) begin
      temp_q <= temp_in;
      seen   <= 1'b1;
    end
  end

  // Free-running ramp tick divider
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : (tick_cnt + 1'b1);
  end

  // Duty command moves only on ramp ticks
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)     speed <= 8'd0;
    else if (tick) speed <= speed_nx;
  end

endmodule
`default_nettype wire
